// File: rtl/main_memory_if.sv
// main_memory_if: line-granular request/response bus between a cache controller and main memory
// Ports (signals):
//   read_en_mem  - line read request (level)
//   write_en_mem - line write request (level)
//   addr_mem     - byte address of the line
//   wdata_mem    - write line data
//   rdata_mem    - read line data, held until the next read completes
//   ready_mem    - one-cycle completion pulse
//   busy_mem     - memory is not idle
//   protocol_err - one-cycle pulse when read and write were requested together at accept
// Modports: master (cache side) drives requests, slave (memory side) drives responses.
interface main_memory_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                  read_en_mem;
    logic                  write_en_mem;
    logic [ADDR_WIDTH-1:0] addr_mem;
    logic [LINE_WIDTH-1:0] wdata_mem;
    logic [LINE_WIDTH-1:0] rdata_mem;
    logic                  ready_mem;
    logic                  busy_mem;
    logic                  protocol_err;

    modport master (
        output read_en_mem, write_en_mem, addr_mem, wdata_mem,
        input  rdata_mem, ready_mem, busy_mem, protocol_err
    );

    modport slave (
        input  read_en_mem, write_en_mem, addr_mem, wdata_mem,
        output rdata_mem, ready_mem, busy_mem, protocol_err
    );
endinterface

// File: rtl/main_memory.sv
// main_memory: fixed-latency line-granular memory responder for cache refills and write-backs
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - main_memory_if.slave: requests in (read_en_mem, write_en_mem, addr_mem, wdata_mem),
//         responses out (rdata_mem, ready_mem, busy_mem, protocol_err)
module main_memory #(
    parameter int ADDR_WIDTH    = 32,
    parameter int LINE_WIDTH    = 128,
    parameter int DEPTH_LINES   = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input logic          clk,
    input logic          rst,
    main_memory_if.slave bus
);
    localparam int OFF     = $clog2(LINE_WIDTH / 8);
    localparam int IDX     = $clog2(DEPTH_LINES);
    localparam int MAX_LAT = READ_LATENCY > WRITE_LATENCY ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RESP} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt;
    logic [IDX-1:0]        idx;
    logic [LINE_WIDTH-1:0] wbuf;
    logic [LINE_WIDTH-1:0] rdata_q;
    logic                  perr_q;
    logic                  accept;
    logic                  done;
    logic                  unused_addr;
    logic [LINE_WIDTH-1:0] mem [DEPTH_LINES];

    // Offset and upper address bits are deliberately ignored; lines wrap modulo DEPTH_LINES.
    assign unused_addr = ^bus.addr_mem;
    assign accept      = state == IDLE && (bus.read_en_mem || bus.write_en_mem);
    assign done        = cnt == '0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // A write wins over a simultaneous read; requests outside IDLE are ignored.
    always_comb begin
        state_n = state == IDLE ? (bus.write_en_mem ? WRITE_WAIT : bus.read_en_mem ? READ_WAIT : IDLE)
                : state == RESP ? IDLE
                : done          ? RESP
                : state;
    end

    always_comb begin
        bus.ready_mem    = state == RESP;
        bus.busy_mem     = state != IDLE;
        bus.rdata_mem    = rdata_q;
        bus.protocol_err = perr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            wbuf    <= '0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            perr_q <= accept && bus.read_en_mem && bus.write_en_mem;
            if (accept) begin
                idx <= bus.addr_mem[OFF +: IDX];
                cnt <= bus.write_en_mem ? WR_LOAD : RD_LOAD;
                if (bus.write_en_mem) wbuf <= bus.wdata_mem;
            end else if ((state == READ_WAIT || state == WRITE_WAIT) && !done) begin
                cnt <= cnt - CW'(1);
            end
            if (state == READ_WAIT && done) rdata_q <= mem[idx];
        end
    end

    // Storage is never cleared; a reset at the commit edge aborts the write.
    always_ff @(posedge clk) begin
        if (!rst && state == WRITE_WAIT && done) mem[idx] <= wbuf;
    end
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: randomized self-checking bench for main_memory against a line-array reference model
module tb_main_memory;
    localparam int RL = 4;
    localparam int WL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [127:0] ref_mem [1024];
    bit           ref_ok [1024];
    logic [127:0] last_rd = '0;

    main_memory_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) bus_a ();
    main_memory_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) bus_b ();

    main_memory #(.READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    main_memory #(.READ_LATENCY(1), .WRITE_LATENCY(7)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) & 32'h3FF);
    endfunction

    // One request on dut_a; optional noise drives ignored requests to the same address while busy.
    task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [127:0] d, input bit noise);
        int lat;
        int i;
        i = line_of(a);
        @(negedge clk);
        bus_a.read_en_mem = rd;
        bus_a.write_en_mem = wr;
        bus_a.addr_mem = a;
        bus_a.wdata_mem = d;
        @(posedge clk);
        #1;
        bus_a.read_en_mem = 1'b0;
        bus_a.write_en_mem = 1'b0;
        bus_a.addr_mem = $urandom;
        bus_a.wdata_mem = {$urandom, $urandom, $urandom, $urandom};
        if (wr) begin
            ref_mem[i] = d;
            ref_ok[i] = 1'b1;
        end else if (rd) begin
            last_rd = ref_mem[i];
        end
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("perr", bus_a.protocol_err, k == 1 && rd && wr);
            check("busy", bus_a.busy_mem, 1'b1);
            if (bus_a.ready_mem) begin
                lat = k;
                break;
            end
            if (noise) begin
                bus_a.read_en_mem = 1'($urandom);
                bus_a.write_en_mem = 1'($urandom);
                bus_a.addr_mem = a;
                bus_a.wdata_mem = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        bus_a.read_en_mem = 1'b0;
        bus_a.write_en_mem = 1'b0;
        check("latency", 128'(lat), 128'((wr ? WL : RL) + 1));
        check("rdata", bus_a.rdata_mem, last_rd);
        @(negedge clk);
        check("ready_once", bus_a.ready_mem, 1'b0);
        check("idle", bus_a.busy_mem, 1'b0);
        check("rdata_held", bus_a.rdata_mem, last_rd);
    endtask

    // Holds a request level on dut_b and measures first completion and accept spacing.
    task automatic sweep(input logic wr, input logic [127:0] d, input int lat_exp);
        int first;
        int second;
        first = -1;
        second = -1;
        @(negedge clk);
        bus_b.read_en_mem = !wr;
        bus_b.write_en_mem = wr;
        bus_b.addr_mem = 32'h30;
        bus_b.wdata_mem = d;
        for (int k = 1; k <= 40 && second < 0; k++) begin
            @(negedge clk);
            if (bus_b.ready_mem) begin
                if (first < 0) first = k;
                else second = k;
            end
        end
        bus_b.read_en_mem = 1'b0;
        bus_b.write_en_mem = 1'b0;
        check("b_first", 128'(first), 128'(lat_exp + 1));
        check("b_gap", 128'(second - first), 128'(lat_exp + 2));
    endtask

    initial begin
        logic [127:0] la, lb, lc;
        bus_a.read_en_mem = 1'b0;
        bus_a.write_en_mem = 1'b0;
        bus_a.addr_mem = '0;
        bus_a.wdata_mem = '0;
        bus_b.read_en_mem = 1'b0;
        bus_b.write_en_mem = 1'b0;
        bus_b.addr_mem = '0;
        bus_b.wdata_mem = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus_a.ready_mem, 1'b0);
        check("rst_busy", bus_a.busy_mem, 1'b0);
        check("rst_rdata", bus_a.rdata_mem, '0);
        check("rst_perr", bus_a.protocol_err, 1'b0);
        check("rst_b_rdata", bus_b.rdata_mem, '0);
        rst = 1'b0;

        op(1'b0, 1'b1, 32'h40, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b0);
        op(1'b1, 1'b0, 32'h40, '0, 1'b0);

        la = {$urandom, $urandom, $urandom, $urandom};
        op(1'b0, 1'b1, 32'h0000_0000, la, 1'b0);
        op(1'b1, 1'b0, 32'h0000_000C, '0, 1'b0);
        op(1'b1, 1'b0, 32'h0000_4000, '0, 1'b0);

        op(1'b0, 1'b1, 32'h80, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        op(1'b1, 1'b0, 32'h80, '0, 1'b1);
        op(1'b1, 1'b0, 32'h80, '0, 1'b0);

        op(1'b1, 1'b1, 32'h100, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        op(1'b1, 1'b0, 32'h100, '0, 1'b0);

        la = {$urandom, $urandom, $urandom, $urandom};
        lb = ~la;
        op(1'b0, 1'b1, 32'h200, la, 1'b0);
        @(negedge clk);
        bus_a.write_en_mem = 1'b1;
        bus_a.addr_mem = 32'h200;
        bus_a.wdata_mem = lb;
        @(posedge clk);
        #1;
        bus_a.write_en_mem = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_ready", bus_a.ready_mem, 1'b0);
        check("rstmid_busy", bus_a.busy_mem, 1'b0);
        check("rstmid_rdata", bus_a.rdata_mem, '0);
        check("rstmid_perr", bus_a.protocol_err, 1'b0);
        rst = 1'b0;
        last_rd = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rstmid_noready", bus_a.ready_mem, 1'b0);
        end
        op(1'b1, 1'b0, 32'h200, '0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int sel;
            int i;
            logic [31:0] a;
            logic rd, wr;
            sel = int'($urandom_range(0, 3));
            i = int'($urandom_range(0, 15));
            a = ($urandom & ~32'h0000_3FF0) | (32'(i) << 4);
            rd = sel >= 2;
            wr = sel != 2 || !ref_ok[i];
            op(rd, wr, a, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
        end

        lc = {$urandom, $urandom, $urandom, $urandom};
        sweep(1'b1, lc, 7);
        sweep(1'b0, '0, 1);
        check("b_rdata", bus_b.rdata_mem, lc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
